// File: rtl/fir_pkg.sv
// Shared constants, coefficient tables and helpers for the audio decimating FIR.
// Latency: n/a (package).
// Backpressure: n/a (package).
package fir_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BITS       = 10;
  localparam int QUANT_ONE  = 1 << BITS;
  localparam int COEFF_LEN  = 32;

  // Coefficient table selectors; the h0-only set isolates sign/rounding behaviour.
  localparam int COEFF_SET_AUDIO   = 0;
  localparam int COEFF_SET_H0_TEST = 1;

  typedef enum logic [1:0] {LOAD, MAC, WRITE} fir_state_t;

  // Symmetric low-pass taps in Q(BITS); DC gain is 980/1024.
  localparam int AUDIO_LPR_COEFFS [COEFF_LEN] = '{
    -2, -3, -4, -3,  0,  6, 14, 22,
    29, 36, 45, 55, 64, 72, 78, 81,
    81, 78, 72, 64, 55, 45, 36, 29,
    22, 14,  6,  0, -3, -4, -3, -2
  };

  // Divide by 2**BITS with truncation toward zero (signed division, not a shift).
  function automatic logic signed [2*DATA_WIDTH-1:0] dequantize(
    input logic signed [2*DATA_WIDTH-1:0] p
  );
    return p / (2*DATA_WIDTH)'(QUANT_ONE);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] fir_coeff(input int set, input int idx);
    if (set == COEFF_SET_H0_TEST)
      return (idx == 0) ? DATA_WIDTH'(3) : '0;
    return DATA_WIDTH'(AUDIO_LPR_COEFFS[idx % COEFF_LEN]);
  endfunction

endpackage

// File: rtl/fir_tap_buffer.sv
// Circular sample history: one write port, combinational read at (newest - rd_offset).
// Latency: write visible to reads the cycle after wr_en.
// Backpressure: none; writer decides when to write.
module fir_tap_buffer
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 32,
  parameter int PTR_W    = $clog2(NUM_TAPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic [PTR_W-1:0]      rd_offset,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  logic [DATA_WIDTH-1:0] mem [NUM_TAPS];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      newest;

  // Slot written most recently; pointer arithmetic wraps because NUM_TAPS is a power of two.
  assign newest = wptr - 1'b1;
  assign rd_dat = mem[newest - rd_offset];

  // Store incoming samples and advance the write pointer; reset zeroes the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      for (int i = 0; i < NUM_TAPS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wptr] <= wr_dat;
      wptr      <= wptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_decim.sv
// Decimating low-pass FIR: buffers DECIMATION inputs, then one sequential MAC pass per output.
// Latency: last input pop to output push is NUM_TAPS+1 cycles minimum.
// Backpressure: holds in WRITE while y_out_full (no input pops); idles in LOAD while x_in_empty.
module fir_decim
  import fir_pkg::*;
#(
  parameter int NUM_TAPS   = 32,
  parameter int DECIMATION = 8,
  parameter int COEFF_SET  = COEFF_SET_AUDIO
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  x_in_rd_en,
  input  logic                  x_in_empty,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  y_out_wr_en,
  input  logic                  y_out_full
);

  localparam int TAP_W = $clog2(NUM_TAPS);
  localparam int CNT_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIMATION - 1);

  fir_state_t                     state;
  fir_state_t                     state_nxt;
  logic [CNT_W-1:0]               cnt;
  logic [TAP_W-1:0]               tap;
  logic [DATA_WIDTH-1:0]          acc;
  logic [DATA_WIDTH-1:0]          tap_dat;
  logic signed [DATA_WIDTH-1:0]   h_cur;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH-1:0]          mac_term;
  logic                           last_pop;

  fir_tap_buffer #(
    .NUM_TAPS (NUM_TAPS)
  ) u_tap_buffer (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (x_in_rd_en),
    .wr_dat    (x_in),
    .rd_offset (tap),
    .rd_dat    (tap_dat)
  );

  // Full-precision signed product, dequantized and then wrapped back to sample width.
  assign h_cur    = fir_coeff(COEFF_SET, int'(tap));
  assign prod     = (2*DATA_WIDTH)'(h_cur) * (2*DATA_WIDTH)'($signed(tap_dat));
  assign mac_term = DATA_WIDTH'(dequantize(prod));
  assign last_pop = x_in_rd_en && (cnt == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Next state and FIFO strobes; strobes are suppressed during reset so no transfer is implied.
  always_comb begin
    state_nxt   = state;
    x_in_rd_en  = 1'b0;
    y_out_wr_en = 1'b0;
    y_out       = '0;
    case (state)
      LOAD: begin
        x_in_rd_en = !x_in_empty && !rst;
        if (x_in_rd_en && (cnt == LAST_CNT)) state_nxt = MAC;
      end
      MAC: begin
        if (tap == LAST_TAP) state_nxt = WRITE;
      end
      WRITE: begin
        y_out_wr_en = !y_out_full && !rst;
        if (y_out_wr_en) begin
          y_out     = acc;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Decimation counter, tap index and accumulator; a reset mid-MAC discards the partial sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tap <= '0;
      acc <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (last_pop) begin
            cnt <= '0;
            tap <= '0;
            acc <= '0;
          end else if (x_in_rd_en) begin
            cnt <= cnt + 1'b1;
          end
        end
        MAC: begin
          acc <= acc + mac_term;
          tap <= tap + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_decim.sv
// Scoreboard bench for fir_decim: reference model predicts each output as inputs are popped.
// Latency: outputs compared when the DUT pushes them.
// Backpressure: exercises both input starvation and output-full stalls.
module tb_fir_decim;
  import fir_pkg::*;

  localparam int NT  = 32;
  localparam int DEC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_in_rd_en, x_in_empty, y_out_wr_en, y_out_full;
  logic [31:0] x_in, y_out;
  logic        h0_rd_en, h0_empty, h0_wr_en;
  logic [31:0] h0_x, h0_y;

  int n_checks = 0;
  int n_pass   = 0;
  int hist[$];
  int exp_q[$];
  int stim[$];
  int stim_save[$];
  int mdl_cnt  = 0;
  int push_cnt = 0;
  int last_y   = 0;

  always #5 clk = ~clk;

  fir_decim #(.NUM_TAPS(NT), .DECIMATION(DEC), .COEFF_SET(COEFF_SET_AUDIO)) dut (
    .clk(clk), .rst(rst), .x_in_rd_en(x_in_rd_en), .x_in_empty(x_in_empty), .x_in(x_in),
    .y_out(y_out), .y_out_wr_en(y_out_wr_en), .y_out_full(y_out_full)
  );

  fir_decim #(.NUM_TAPS(NT), .DECIMATION(1), .COEFF_SET(COEFF_SET_H0_TEST)) dut_h0 (
    .clk(clk), .rst(rst), .x_in_rd_en(h0_rd_en), .x_in_empty(h0_empty), .x_in(h0_x),
    .y_out(h0_y), .y_out_wr_en(h0_wr_en), .y_out_full(1'b0)
  );

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
  endtask

  // Reference: y = sum_i trunc0(h[i]*x[n-i] / 1024), wrapping at 32 bits.
  function automatic int model_y();
    int     acc = 0;
    int     n   = hist.size();
    longint xv, p;
    for (int i = 0; i < NT; i++) begin
      xv  = (n - 1 - i >= 0) ? longint'(hist[n-1-i]) : 64'sd0;
      p   = longint'(AUDIO_LPR_COEFFS[i]) * xv;
      acc = acc + int'(p / 1024);
    end
    return acc;
  endfunction

  // Observe transfers mid-cycle; predict on pop, compare on push.
  always @(negedge clk) begin
    if (rst) begin
      hist.delete();
      exp_q.delete();
      mdl_cnt = 0;
    end else begin
      chk("pop_while_empty", longint'(x_in_rd_en & x_in_empty), 0);
      chk("push_while_full", longint'(y_out_wr_en & y_out_full), 0);
      chk("pop_and_push", longint'(x_in_rd_en & y_out_wr_en), 0);
      if (!y_out_wr_en) chk("y_idle_zero", longint'(y_out), 0);
      if (x_in_rd_en) begin
        hist.push_back(int'($signed(x_in)));
        mdl_cnt++;
        if (mdl_cnt == DEC) begin
          mdl_cnt = 0;
          exp_q.push_back(model_y());
        end
      end
      if (y_out_wr_en) begin
        push_cnt++;
        last_y = int'($signed(y_out));
        chk("push_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("y_out", longint'($signed(y_out)), longint'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    x_in_empty = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Present stim[] FWFT-style; optionally starve the DUT at random.
  task automatic feed(input bit stall);
    int i = 0;
    int guard = 0;
    bit took;
    while (i < stim.size() && guard < 5000) begin
      if (stall && $urandom_range(0, 2) == 0) x_in_empty = 1'b1;
      else begin
        x_in_empty = 1'b0;
        x_in = stim[i];
      end
      @(negedge clk);
      took = x_in_rd_en;
      @(posedge clk);
      #1;
      if (took) i++;
      guard++;
    end
    x_in_empty = 1'b1;
    chk("feed_done", i, stim.size());
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 300) begin
      tick(1);
      guard++;
    end
    tick(2);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic h0_run(input int xv, input int expv);
    int guard = 0;
    bit got = 1'b0;
    h0_x = xv;
    h0_empty = 1'b0;
    while (!got && guard < 50) begin
      @(negedge clk);
      got = h0_rd_en;
      @(posedge clk);
      #1;
      guard++;
    end
    h0_empty = 1'b1;
    chk("h0_pop", longint'(got), 1);
    got = 1'b0;
    guard = 0;
    while (!got && guard < 100) begin
      @(negedge clk);
      if (h0_wr_en) begin
        got = 1'b1;
        chk("h0_y", longint'($signed(h0_y)), longint'(expv));
      end
      @(posedge clk);
      #1;
      guard++;
    end
    chk("h0_push", longint'(got), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n_pop, n_push, n_ynz, sum_h, sum_h8;
    sum_h = 0;
    sum_h8 = 0;
    for (int i = 0; i < NT; i++) begin
      sum_h += AUDIO_LPR_COEFFS[i];
      if (i < 8) sum_h8 += AUDIO_LPR_COEFFS[i];
    end

    // Reset state: strobes low and y_out zero even with input data available.
    rst = 1'b1; x_in_empty = 1'b0; x_in = 32'd5; y_out_full = 1'b0;
    h0_empty = 1'b1; h0_x = '0;
    tick(3);
    chk("rst_rd_en", longint'(x_in_rd_en), 0);
    chk("rst_wr_en", longint'(y_out_wr_en), 0);
    chk("rst_y_out", longint'(y_out), 0);
    rst = 1'b0;
    x_in_empty = 1'b1;
    tick(2);

    // Impulse: four pushes h[7], h[15], h[23], h[31].
    p0 = push_cnt;
    stim.delete();
    stim.push_back(1024);
    repeat (31) stim.push_back(0);
    feed(1'b0);
    drain();
    chk("impulse_pushes", push_cnt - p0, 4);
    chk("impulse_last", last_y, AUDIO_LPR_COEFFS[31]);

    // DC: steady-state output equals the sum of coefficients.
    p0 = push_cnt;
    stim.delete();
    repeat (64) stim.push_back(1024);
    feed(1'b0);
    drain();
    chk("dc_pushes", push_cnt - p0, 8);
    chk("dc_steady", last_y, sum_h);

    // Backpressure: output full for the whole MAC + 20+ cycles of WRITE.
    y_out_full = 1'b1;
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(i * 300 - 1000);
    feed(1'b0);
    x_in_empty = 1'b0;
    x_in = 32'd777;
    n_pop = 0; n_push = 0; n_ynz = 0;
    repeat (55) begin
      @(negedge clk);
      if (x_in_rd_en) n_pop++;
      if (y_out_wr_en) n_push++;
      if (y_out != 0) n_ynz++;
    end
    @(posedge clk);
    #1;
    chk("bp_pops", n_pop, 0);
    chk("bp_pushes", n_push, 0);
    chk("bp_y_quiet", n_ynz, 0);
    x_in_empty = 1'b1;
    p0 = push_cnt;
    y_out_full = 1'b0;
    tick(3);
    chk("bp_release_push", push_cnt - p0, 1);
    drain();

    // Starvation: same random stimulus with and without input stalls.
    stim.delete();
    for (int i = 0; i < 48; i++) stim.push_back(int'($urandom_range(0, 40000)) - 20000);
    stim_save = stim;
    do_reset();
    p0 = push_cnt;
    feed(1'b0);
    drain();
    chk("nostall_pushes", push_cnt - p0, 6);
    do_reset();
    stim = stim_save;
    p0 = push_cnt;
    feed(1'b1);
    drain();
    chk("stall_pushes", push_cnt - p0, 6);

    // Mid-op reset at MAC tap 10: no push, then fresh history.
    do_reset();
    stim.delete();
    repeat (8) stim.push_back(500);
    feed(1'b0);
    p0 = push_cnt;
    tick(10);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(40);
    chk("midop_no_push", push_cnt - p0, 0);
    stim.delete();
    repeat (8) stim.push_back(1024);
    feed(1'b0);
    drain();
    chk("midop_after", last_y, sum_h8);

    // Sign and truncation toward zero with the h0-only table, decimation 1.
    h0_run(-1, 0);
    h0_run(-1024, -3);
    h0_run(2048, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
